load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 42 ++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and access-size decoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_RESP
  } lsu_state_t;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: is_legal = 1'b1;
      default:                        is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: lane mask, store-data rotation and load extraction
// with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic [7:0]  o_m8,
  output logic [31:0] o_wrot,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_sh;
  logic [7:0]  w_ones;
  logic [31:0] w_rd;

  always_comb begin
    w_sh = {i_off, 3'b000};
    case (size_of(i_funct3))
      3'd1:    w_ones = 8'h01;
      3'd2:    w_ones = 8'h03;
      default: w_ones = 8'h0F;
    endcase
    o_m8 = w_ones << i_off;

    // A shift of 32 yields zero, so off=0 leaves the word untouched.
    o_wrot = (i_wdata << w_sh) | (i_wdata >> (6'd32 - {1'b0, w_sh}));

    w_rd = 32'({i_hi, i_lo} >> w_sh);
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_rd[7]}}, w_rd[7:0]};
      F3_H:    o_rdata = {{16{w_rd[15]}}, w_rd[15:0]};
      F3_BU:   o_rdata = {24'h0, w_rd[7:0]};
      F3_HU:   o_rdata = {16'h0, w_rd[15:0]};
      default: o_rdata = w_rd;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store master for a word-organised byte-lane memory; splits accesses
// that cross a word boundary into two word cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [2:0]               mem_RE,
  output logic [3:0]               mem_WE,
  output logic [7:0]               mem_WD1,
  output logic [7:0]               mem_WD2,
  output logic [7:0]               mem_WD3,
  output logic [7:0]               mem_WD4,
  input  logic [DATA_WIDTH-1:0]    mem_RD
);

  lsu_state_t               r_state, w_next;
  logic                     r_store;
  logic [2:0]               r_funct3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_lo;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_err;

  logic                     w_span;
  logic [DATA_WIDTH-1:0]    w_lo, w_hi;
  logic [7:0]               w_m8;
  logic [DATA_WIDTH-1:0]    w_wrot, w_ldata;
  logic [ADDRESS_WIDTH-1:0] w_base;

  assign w_span = ({1'b0, r_addr[1:0]} + size_of(r_funct3)) > 3'd4;
  assign w_base = {r_addr[ADDRESS_WIDTH-1:2], 2'b00};

  lsu_align u_align (
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .i_wdata  (r_wdata),
    .i_lo     (w_lo),
    .i_hi     (w_hi),
    .o_m8     (w_m8),
    .o_wrot   (w_wrot),
    .o_rdata  (w_ldata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RESP: w_next = !req_valid ? S_IDLE
                             : (is_legal(req_funct3) ? S_ACC0 : S_RESP);
      S_ACC0:         w_next = w_span ? S_ACC1 : S_RESP;
      S_ACC1:         w_next = S_RESP;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE) || (r_state == S_RESP);
    resp_valid = (r_state == S_RESP);
    resp_rdata = r_rdata;
    resp_err   = r_err;
    mem_RE     = 3'b111;
    mem_A      = '0;
    mem_WE     = '0;
    {mem_WD4, mem_WD3, mem_WD2, mem_WD1} = '0;
    w_lo       = r_lo;
    w_hi       = '0;
    case (r_state)
      S_ACC0: begin
        mem_A  = w_base;
        mem_WE = r_store ? w_m8[3:0] : 4'b0000;
        {mem_WD4, mem_WD3, mem_WD2, mem_WD1} = w_wrot;
        w_lo   = mem_RD;
      end
      S_ACC1: begin
        mem_A  = w_base + ADDRESS_WIDTH'(4);
        mem_WE = r_store ? w_m8[7:4] : 4'b0000;
        {mem_WD4, mem_WD3, mem_WD2, mem_WD1} = w_wrot;
        w_hi   = mem_RD;
      end
      default: ;
    endcase
  end

  // Response fields are computed during the final access cycle so they are
  // registered on entry to RESP and cleared on every other cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_store  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_lo     <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == S_ACC0) r_lo <= mem_RD;
      r_rdata <= '0;
      r_err   <= 1'b0;
      if (w_next == S_RESP) begin
        if ((r_state == S_ACC0) || (r_state == S_ACC1))
          r_rdata <= r_store ? '0 : w_ldata;
        else
          r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random traffic against a
// byte-addressed reference memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic [2:0]  mem_RE;
  logic [3:0]  mem_WE;
  logic [7:0]  mem_WD1, mem_WD2, mem_WD3, mem_WD4;
  logic [31:0] mem_RD;

  int checks   = 0;
  int failures = 0;

  logic [31:0] env_mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_A(mem_A), .mem_RE(mem_RE), .mem_WE(mem_WE),
    .mem_WD1(mem_WD1), .mem_WD2(mem_WD2), .mem_WD3(mem_WD3), .mem_WD4(mem_WD4),
    .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    if (env_mem.exists(wa)) return env_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] b);
    logic [31:0] w;
    if (ref_mem.exists(b)) return ref_mem[b];
    w = init_word({b[31:2], 2'b00});
    return w[8*b[1:0] +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input logic [31:0] wa);
    logic [31:0] e;
    for (int k = 0; k < 4; k++) e[8*k +: 8] = ref_byte(wa + 32'(k));
    chk("mem_word", rd_word(wa), e);
  endtask

  // Memory environment: answers the current bus address and commits lane writes.
  task automatic env_cycle();
    logic [31:0] w;
    w = rd_word(mem_A);
    mem_RD = w;
    if (mem_WE[0]) w[7:0]   = mem_WD1;
    if (mem_WE[1]) w[15:8]  = mem_WD2;
    if (mem_WE[2]) w[23:16] = mem_WD3;
    if (mem_WE[3]) w[31:24] = mem_WD4;
    if (mem_WE != 4'b0000) env_mem[mem_A] = w;
  endtask

  // Entered and left on a falling edge; a following call is back-to-back.
  task automatic run_req(input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] got);
    int          sz, off, nacc, pos;
    bit          legal;
    logic [31:0] ea, ew, v;
    logic [3:0]  ewe;
    legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = int'(addr[1:0]);
    nacc  = (off + sz > 4) ? 2 : 1;
    chk("req_ready_accept", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (legal) begin
      for (int c = 0; c < nacc; c++) begin
        ea  = {addr[31:2], 2'b00} + 32'(4 * c);
        ewe = 4'b0000;
        ew  = '0;
        for (int l = 0; l < 4; l++) begin
          pos = 4 * c + l;
          if (st && pos >= off && pos < off + sz) ewe[l] = 1'b1;
          ew[8*l +: 8] = wd[8*((l - off) & 3) +: 8];
        end
        chk("acc_ready", {31'b0, req_ready}, 32'd0);
        chk("acc_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("acc_mem_A", mem_A, ea);
        chk("acc_mem_WE", {28'b0, mem_WE}, {28'b0, ewe});
        chk("acc_mem_RE", {29'b0, mem_RE}, 32'd7);
        chk("acc_mem_WD", {mem_WD4, mem_WD3, mem_WD2, mem_WD1}, ew);
        env_cycle();
        @(negedge clk);
      end
    end
    v = '0;
    if (legal && st) begin
      for (int k = 0; k < sz; k++) ref_mem[addr + 32'(k)] = wd[8*k +: 8];
    end else if (legal) begin
      for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_byte(addr + 32'(k));
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8*sz)) - 32'h1);
    end
    got = resp_rdata;
    chk("resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("resp_err", {31'b0, resp_err}, {31'b0, !legal});
    chk("resp_rdata", resp_rdata, v);
    chk("resp_mem_WE", {28'b0, mem_WE}, 32'd0);
    if (legal && st) begin
      chk_word({addr[31:2], 2'b00});
      if (nacc == 2) chk_word({addr[31:2], 2'b00} + 32'd4);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("idle_rdata", resp_rdata, 32'd0);
    chk("idle_err", {31'b0, resp_err}, 32'd0);
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    chk("idle_mem_WE", {28'b0, mem_WE}, 32'd0);
  endtask

  initial begin
    logic [31:0] got, a;
    logic [2:0]  f;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_RD = '0;
    #2;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_WE", {28'b0, mem_WE}, 32'd0);
    chk("rst_mem_A", mem_A, 32'd0);
    chk("rst_mem_WD", {mem_WD4, mem_WD3, mem_WD2, mem_WD1}, 32'd0);
    chk("rst_mem_RE", {29'b0, mem_RE}, 32'd7);
    @(negedge clk);
    rst = 1'b0;

    run_req(1'b1, 3'b010, 32'h0001_0000, 32'hDEADBEEF, got);
    chk_word(32'h0001_0000);
    idle_cycle();
    run_req(1'b1, 3'b010, 32'h0001_0000, 32'h8011_2233, got);
    run_req(1'b0, 3'b000, 32'h0001_0003, 32'h0, got);
    chk("lb_sign_const", got, 32'hFFFF_FF80);
    run_req(1'b0, 3'b100, 32'h0001_0003, 32'h0, got);
    chk("lbu_zero_const", got, 32'h0000_0080);
    idle_cycle();
    run_req(1'b1, 3'b001, 32'h0001_0003, 32'h0000_A1B2, got);
    run_req(1'b1, 3'b010, 32'h0001_0000, 32'h4433_2211, got);
    run_req(1'b1, 3'b010, 32'h0001_0004, 32'h8877_6655, got);
    run_req(1'b0, 3'b010, 32'h0001_0002, 32'h0, got);
    chk("lw_split_const", got, 32'h6655_4433);
    run_req(1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0, got);
    run_req(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_1357, got);
    run_req(1'b1, 3'b011, 32'h0001_0000, 32'h1234_5678, got);
    run_req(1'b0, 3'b111, 32'h0001_0001, 32'h0, got);
    chk_word(32'h0001_0000);
    idle_cycle();

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8 + $urandom_range(0, 7);
      else                           a = 32'h0003_0000 + $urandom_range(0, 31);
      f = 3'($urandom_range(0, 7));
      run_req(1'($urandom), f, a, $urandom, got);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Reset during the second half of a split store.
    idle_cycle();
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0002_0002; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_acc0_WE", {28'b0, mem_WE}, 32'hC);
    env_cycle();
    ref_mem[32'h0002_0002] = 8'h0D;
    ref_mem[32'h0002_0003] = 8'hF0;
    @(negedge clk);
    chk("rstmid_acc1_WE", {28'b0, mem_WE}, 32'h3);
    chk("rstmid_acc1_A", mem_A, 32'h0002_0004);
    rst = 1'b1;
    #1;
    chk("rstmid_WE_drop", {28'b0, mem_WE}, 32'd0);
    chk("rstmid_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle_cycle();
    chk_word(32'h0002_0000);
    chk_word(32'h0002_0004);
    run_req(1'b0, 3'b010, 32'h0002_0002, 32'h0, got);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
